// File: rtl/banked_burst_memory_reader_if.sv
// Command, bank-read and beat-stream signals of the banked burst reader.
// The reader sits on the master modport; the environment (tile controller,
// SRAM banks and beat consumer) sits on the slave modport.
interface banked_burst_memory_reader_if #(
    parameter int WORD_WIDTH = 512,
    parameter int NUM_ROWS   = 128,
    parameter int NUM_BANKS  = 4
);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    // command channel
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic                            cmd_burst;
    logic [BANK_W-1:0]               cmd_bank;
    logic [ROW_W-1:0]                cmd_row;
    logic [ROW_W:0]                  cmd_len;

    // bank read port
    logic [NUM_BANKS-1:0]            mem_en;
    logic [ROW_W-1:0]                mem_addr;
    logic [NUM_BANKS*WORD_WIDTH-1:0] mem_rdata;

    // beat stream
    logic [WORD_WIDTH-1:0]           data_out;
    logic [ROW_W-1:0]                data_row;
    logic                            data_last;
    logic                            data_valid;
    logic                            data_ready;

    modport master (
        input  cmd_valid, cmd_burst, cmd_bank, cmd_row, cmd_len,
        output cmd_ready,
        output mem_en, mem_addr,
        input  mem_rdata,
        output data_out, data_row, data_last, data_valid,
        input  data_ready
    );

    modport slave (
        output cmd_valid, cmd_burst, cmd_bank, cmd_row, cmd_len,
        input  cmd_ready,
        input  mem_en, mem_addr,
        output mem_rdata,
        input  data_out, data_row, data_last, data_valid,
        output data_ready
    );
endinterface

// File: rtl/banked_burst_memory_reader.sv
// Banked burst reader: takes single-row or burst read commands for one of
// NUM_BANKS synchronous SRAM banks and streams the rows out with full
// backpressure. Reads are only issued while in-flight reads plus buffered
// beats leave room in the output FIFO, so the FIFO can never overflow.
module banked_burst_memory_reader #(
    parameter int WORD_WIDTH   = 512,
    parameter int NUM_ROWS     = 128,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    banked_burst_memory_reader_if.master         bus,
    output logic                                 busy_o,
    output logic                                 scan_done_o
);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int LEN_W  = ROW_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_ROWS);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [LEN_W-1:0]    len_sel;
    logic                issue;

    // in-flight read tracking: one stage per cycle of bank read latency
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_last_q;
    logic [ROW_W-1:0]        pipe_row_q [READ_LATENCY];

    // output FIFO
    logic [WORD_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [ROW_W-1:0]        fifo_row_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [CNT_W:0]          occupancy;
    logic                    push, pop;

    assign push      = pipe_vld_q[READ_LATENCY-1];
    assign pop       = bus.data_valid && bus.data_ready;
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};

    // state register and command context
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            bank_q      <= '0;
            row_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            remaining_q <= remaining_d;
        end
    end

    // next-state logic: command accept, credit-gated issue, drain, done pulse
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        row_d       = row_q;
        remaining_d = remaining_q;
        len_sel     = '0;
        issue       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    bank_d = bus.cmd_bank;
                    row_d  = bus.cmd_row;
                    if (bus.cmd_burst)
                        len_sel = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
                    else
                        len_sel = LEN_W'(1);
                    remaining_d = len_sel;
                    // an empty burst passes through DRAIN, which sees nothing
                    // outstanding and moves straight on to DONE
                    state_d = (len_sel == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (occupancy < DEPTH_C) begin
                    issue       = 1'b1;
                    row_d       = row_q + ROW_W'(1);   // wraps within the bank
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // leave as the final beat is being accepted so the done pulse
                // lands in the very next cycle
                if (inflight_q == '0 &&
                    (count_q == '0 || (count_q == CNT_W'(1) && pop)))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // first in-flight stage captures the issued row tag and last flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld_q[0]  <= 1'b0;
            pipe_last_q[0] <= 1'b0;
            pipe_row_q[0]  <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue && (remaining_q == LEN_W'(1));
            pipe_row_q[0]  <= row_q;
        end
    end

    // remaining in-flight stages shift the tag along with the bank latency
    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pipe_vld_q[gi]  <= 1'b0;
                    pipe_last_q[gi] <= 1'b0;
                    pipe_row_q[gi]  <= '0;
                end else begin
                    pipe_vld_q[gi]  <= pipe_vld_q[gi-1];
                    pipe_last_q[gi] <= pipe_last_q[gi-1];
                    pipe_row_q[gi]  <= pipe_row_q[gi-1];
                end
            end
        end
    endgenerate

    // occupancy counters: reads in flight and beats buffered
    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        if (issue && !push)
            inflight_d = inflight_q + CNT_W'(1);
        else if (!issue && push)
            inflight_d = inflight_q - CNT_W'(1);
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push && pop)
            count_d = count_q - CNT_W'(1);
    end

    // counters and FIFO pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_TOP) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_TOP) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    // FIFO storage: returning data taken from the latched bank's slice
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.mem_rdata[bank_q*WORD_WIDTH +: WORD_WIDTH];
            fifo_row_q[wr_ptr_q]  <= pipe_row_q[READ_LATENCY-1];
            fifo_last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY-1];
        end
    end

    // outputs; beat fields are forced to zero whenever no beat is presented
    always_comb begin
        bus.cmd_ready  = (state_q == S_IDLE);
        bus.mem_en     = issue ? (NUM_BANKS'(1) << bank_q) : '0;
        bus.mem_addr   = issue ? row_q : '0;
        bus.data_valid = (count_q != '0);
        bus.data_out   = bus.data_valid ? fifo_data_q[rd_ptr_q] : '0;
        bus.data_row   = bus.data_valid ? fifo_row_q[rd_ptr_q]  : '0;
        bus.data_last  = bus.data_valid && fifo_last_q[rd_ptr_q];
        busy_o         = (state_q != S_IDLE);
        scan_done_o    = (state_q == S_DONE);
    end
endmodule

// File: tb/tb_banked_burst_memory_reader.sv
// Directed bench for the banked burst reader: single reads, full bursts,
// row wrap, random backpressure, length clamp, empty burst and reset mid-burst.
module tb_banked_burst_memory_reader;
    localparam int WW = 512;
    localparam int NR = 128;
    localparam int NB = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, scan_done;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ready_pct = 100;

    banked_burst_memory_reader_if #(.WORD_WIDTH(WW), .NUM_ROWS(NR), .NUM_BANKS(NB)) bus_if ();

    banked_burst_memory_reader #(
        .WORD_WIDTH(WW), .NUM_ROWS(NR), .NUM_BANKS(NB), .READ_LATENCY(1), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus_if),
        .busy_o      (busy),
        .scan_done_o (scan_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WW-1:0] pat(input int b, input int r);
        logic [31:0] w;
        w = {4'hB, 4'(b), 1'b0, 7'(r), 16'h5AC3};
        return {16{w}};
    endfunction

    // bank model: one-cycle synchronous read; idle banks return junk
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            bus_if.mem_rdata[b*WW +: WW] <= bus_if.mem_en[b] ? pat(b, int'(bus_if.mem_addr))
                                                              : {16{32'hDEADBEEF}};
    end

    // consumer ready pattern
    always @(posedge clk) begin
        #1 bus_if.data_ready = ($urandom_range(0, 99) < ready_pct);
    end

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // monitor state (written only by the monitor)
    int   accept_cyc, first_en, first_valid, last_pop, done_cyc;
    int   en_cnt, valid_cnt, done_cnt, issues, pops;
    int   cur_bank, cur_row;
    int   en_err = 0, addr_err = 0, credit_err = 0, stab_err = 0;
    int   q_row[$];
    bit   q_last[$];
    logic [WW-1:0] q_data[$];
    bit   stall_prev;
    logic [WW-1:0] prev_data;
    int   prev_row;
    bit   prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt = 0; valid_cnt = 0; done_cnt = 0; issues = 0; pops = 0;
            first_en = -1; first_valid = -1; last_pop = -1; done_cyc = -1;
            q_row.delete(); q_last.delete(); q_data.delete();
            stall_prev = 1'b0;
        end else begin
            if (bus_if.cmd_valid && bus_if.cmd_ready) begin
                accept_cyc = cyc; first_en = -1; first_valid = -1; last_pop = -1; done_cyc = -1;
                en_cnt = 0; valid_cnt = 0; done_cnt = 0; issues = 0; pops = 0;
                cur_bank = int'(bus_if.cmd_bank); cur_row = int'(bus_if.cmd_row);
                q_row.delete(); q_last.delete(); q_data.delete();
            end
            if (bus_if.mem_en != '0) begin
                if (first_en < 0) first_en = cyc;
                if (bus_if.mem_en != (NB'(1) << cur_bank)) en_err++;
                if (bus_if.mem_addr != 7'(cur_row + en_cnt)) addr_err++;
                en_cnt++; issues++;
                if (issues - pops > FD) credit_err++;
            end
            if (stall_prev) begin
                if (!bus_if.data_valid || bus_if.data_out !== prev_data ||
                    int'(bus_if.data_row) != prev_row || bus_if.data_last != prev_last)
                    stab_err++;
            end
            if (bus_if.data_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (bus_if.data_valid && bus_if.data_ready) begin
                q_row.push_back(int'(bus_if.data_row));
                q_last.push_back(bus_if.data_last);
                q_data.push_back(bus_if.data_out);
                pops++;
                last_pop = cyc;
            end
            stall_prev = bus_if.data_valid && !bus_if.data_ready;
            prev_data  = bus_if.data_out;
            prev_row   = int'(bus_if.data_row);
            prev_last  = bus_if.data_last;
            if (scan_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_cmd(input bit burst, input int bank, input int row, input int len,
                           input int pct, input bit lat_chk);
        int n;
        bit acc, fin;
        ready_pct = pct;
        n = burst ? ((len > NR) ? NR : len) : 1;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_burst = burst;
        bus_if.cmd_bank  = 2'(bank);
        bus_if.cmd_row   = 7'(row);
        bus_if.cmd_len   = 8'(len);
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus_if.cmd_ready;
            if (!acc) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        check_val("cmd_accept", WW'(acc), WW'(1));
        fin = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(posedge clk);
            fin = (done_cnt != 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("scan_done_seen", WW'(fin), WW'(1));
        check_val("scan_done_pulses", WW'(done_cnt), WW'(1));
        check_val("beat_count", WW'(q_row.size()), WW'(n));
        check_val("mem_en_count", WW'(en_cnt), WW'(n));
        check_val("mem_en_onehot_err", WW'(en_err), WW'(0));
        check_val("mem_addr_err", WW'(addr_err), WW'(0));
        check_val("credit_err", WW'(credit_err), WW'(0));
        check_val("stall_stable_err", WW'(stab_err), WW'(0));
        for (int i = 0; i < q_row.size() && i < n; i++) begin
            check_val("beat_row", WW'(q_row[i]), WW'((row + i) % NR));
            check_val("beat_last", WW'(q_last[i]), WW'(i == n - 1));
            check_val("beat_data", q_data[i], pat(bank, (row + i) % NR));
        end
        if (n > 0) begin
            check_val("done_after_last", WW'(done_cyc - last_pop), WW'(1));
        end else begin
            check_val("len0_done_lat", WW'(done_cyc - accept_cyc), WW'(2));
            check_val("len0_no_valid", WW'(valid_cnt), WW'(0));
        end
        if (lat_chk) begin
            check_val("mem_en_lat", WW'(first_en - accept_cyc), WW'(1));
            check_val("valid_lat", WW'(first_valid - accept_cyc), WW'(3));
        end
        if (pct == 100 && n > 0)
            check_val("throughput", WW'(last_pop - first_valid), WW'(n - 1));
        check_val("cmd_ready_idle", WW'(bus_if.cmd_ready), WW'(1));
        check_val("busy_idle", WW'(busy), WW'(0));
        $display("cmd burst=%0d bank=%0d row=%0d len=%0d beats=%0d", burst, bank, row, len, q_row.size());
    endtask

    initial begin
        bus_if.cmd_valid  = 1'b0;
        bus_if.cmd_burst  = 1'b0;
        bus_if.cmd_bank   = '0;
        bus_if.cmd_row    = '0;
        bus_if.cmd_len    = '0;
        bus_if.data_ready = 1'b1;
        #12;
        check_val("rst_mem_en", WW'(bus_if.mem_en), WW'(0));
        check_val("rst_mem_addr", WW'(bus_if.mem_addr), WW'(0));
        check_val("rst_valid", WW'(bus_if.data_valid), WW'(0));
        check_val("rst_last", WW'(bus_if.data_last), WW'(0));
        check_val("rst_data", bus_if.data_out, WW'(0));
        check_val("rst_row", WW'(bus_if.data_row), WW'(0));
        check_val("rst_busy", WW'(busy), WW'(0));
        check_val("rst_done", WW'(scan_done), WW'(0));
        #10 rst_n = 1'b1;
        #1 check_val("cmd_ready_after_rst", WW'(bus_if.cmd_ready), WW'(1));

        run_cmd(1'b0, 2, 5, 0, 100, 1'b1);      // single read
        run_cmd(1'b1, 0, 0, 128, 100, 1'b1);    // full bank burst
        run_cmd(1'b1, 3, 126, 4, 100, 1'b1);    // row wrap
        run_cmd(1'b1, 1, 40, 32, 30, 1'b0);     // backpressure
        run_cmd(1'b1, 2, 10, 200, 100, 1'b0);   // length clamp
        run_cmd(1'b0, 1, 77, 9, 100, 1'b1);     // single mode ignores length
        run_cmd(1'b1, 0, 3, 0, 100, 1'b0);      // empty burst

        // reset in the middle of a 64-row burst
        ready_pct = 100;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_burst = 1'b1;
        bus_if.cmd_bank  = 2'd0;
        bus_if.cmd_row   = 7'd20;
        bus_if.cmd_len   = 8'd64;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 500 && q_row.size() < 10; i++) @(posedge clk);
        check_val("midrst_beats_before", WW'(q_row.size() >= 10), WW'(1));
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_valid", WW'(bus_if.data_valid), WW'(0));
        check_val("midrst_mem_en", WW'(bus_if.mem_en), WW'(0));
        check_val("midrst_data", bus_if.data_out, WW'(0));
        check_val("midrst_row", WW'(bus_if.data_row), WW'(0));
        check_val("midrst_last", WW'(bus_if.data_last), WW'(0));
        check_val("midrst_busy", WW'(busy), WW'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_val("postrst_no_valid", WW'(valid_cnt), WW'(0));
        check_val("postrst_no_mem_en", WW'(en_cnt), WW'(0));
        check_val("postrst_no_beats", WW'(q_row.size()), WW'(0));
        run_cmd(1'b0, 3, 99, 0, 100, 1'b1);     // fresh single read after reset

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
